// File: rtl/viterbi_traceback.sv
// Purpose: survivor-path traceback for the 8-state (K=4, rate 1/2) Viterbi decoder; stores ACS decisions, traces back, emits bits in forward order.
// Latency: first dout_valid rises n+1 cycles after the beat that closes a block of n steps (n traceback cycles, then registered EMIT).
// Backpressure: din_ready is low outside FILL; during EMIT dout_bit/dout_last hold stable while dout_ready is low.
module viterbi_traceback #(
    parameter int BLOCK_LEN = 16,
    parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [7:0] din_sel,
    input  logic       din_last,
    input  logic [2:0] end_state,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_bit,
    output logic       dout_last
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        TRACE = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W:0]   ONE_N    = (CNT_W+1)'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W:0]   n;
    logic [2:0]       tb_state;

    // Decision memory (one 8-bit ACS vector per step) and decoded-bit buffer.
    logic [7:0]       dec    [BLOCK_LEN];
    logic             bitbuf [BLOCK_LEN];

    logic             in_fire;
    logic             close_blk;
    logic             out_fire;
    logic             trace_done;

    // FSM state register; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake and output generation.
    always_comb begin
        state_nxt  = state;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout_bit   = 1'b0;
        dout_last  = 1'b0;
        in_fire    = 1'b0;
        close_blk  = 1'b0;
        out_fire   = 1'b0;
        trace_done = 1'b0;
        case (state)
            FILL: begin
                // Held low while reset is asserted so nothing is taken during reset.
                din_ready = !rst;
                in_fire   = din_valid && !rst;
                close_blk = in_fire && ((wr_ptr == LAST_IDX) || din_last);
                if (close_blk) begin
                    state_nxt = TRACE;
                end
            end
            TRACE: begin
                trace_done = (idx == '0);
                if (trace_done) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                dout_valid = 1'b1;
                dout_bit   = bitbuf[rd_ptr];
                dout_last  = ({1'b0, rd_ptr} == (n - ONE_N));
                out_fire   = dout_ready;
                if (out_fire && dout_last) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Step counters, block length and the running traceback state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            idx      <= '0;
            rd_ptr   <= '0;
            n        <= '0;
            tb_state <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        // Closing beat starts the traceback at the newest step.
                        if (close_blk) begin
                            wr_ptr   <= '0;
                            n        <= {1'b0, wr_ptr} + ONE_N;
                            tb_state <= end_state;
                            idx      <= wr_ptr;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                TRACE: begin
                    // Predecessor of s is {decision(s), s[2:1]}.
                    tb_state <= {dec[idx][tb_state], tb_state[2:1]};
                    idx      <= idx - 1'b1;
                    if (trace_done) begin
                        rd_ptr <= '0;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (dout_last) begin
                            rd_ptr <= '0;
                            wr_ptr <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory writes: decisions while filling, decoded bits while tracing back.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            dec[wr_ptr] <= din_sel;
        end
        if (state == TRACE) begin
            bitbuf[idx] <= tb_state[0];
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
module tb_viterbi_traceback;

    localparam int BL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] din_sel;
    logic       din_last;
    logic [2:0] end_state;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_bit;
    logic       dout_last;

    int checks   = 0;
    int failures = 0;

    logic       exp_q [$];
    logic [7:0] mdec  [BL];

    viterbi_traceback #(.BLOCK_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_sel    (din_sel),
        .din_last   (din_last),
        .end_state  (end_state),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_bit   (dout_bit),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    // Drives n beats (mode 0: zeros, 1: ones, 2: random), pushes the expected
    // forward-order bits, and returns at the first negedge after the closing edge.
    task automatic send_block(input int n, input int mode, input logic [2:0] es,
                              input bit last_full, input bit idle_gap);
        logic [7:0] sel;
        logic [2:0] st;
        logic       bits [BL];
        for (int i = 0; i < n; i++) begin
            if (idle_gap && i == 1) begin
                @(negedge clk);
                din_valid = 1'b0;
                din_last  = 1'b1;
                din_sel   = 8'hA5;
            end
            @(negedge clk);
            sel = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            mdec[i]   = sel;
            din_valid = 1'b1;
            din_sel   = sel;
            din_last  = (i == n - 1) && ((n < BL) || last_full);
            end_state = (i == n - 1) ? es : ~es;
            checks++;
            if (din_ready !== 1'b1) begin
                failures++;
                $display("FAIL send_ready beat=%0d din_ready=%b expected=1", i, din_ready);
            end
        end
        st = es;
        for (int i = n - 1; i >= 0; i--) begin
            bits[i] = st[0];
            st = {mdec[i][st], st[2:1]};
        end
        for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    // Counts cycles until dout_valid; din_ready must be low throughout.
    task automatic wait_trace(input int n);
        int lat = 0;
        bit rdy_bad = 0;
        while (dout_valid !== 1'b1 && lat < 300) begin
            lat++;
            if (din_ready !== 1'b0) rdy_bad = 1;
            @(negedge clk);
        end
        checks++;
        if (lat != n) begin
            failures++;
            $display("FAIL trace_latency cycles=%0d expected=%0d", lat, n);
        end
        checks++;
        if (rdy_bad) begin
            failures++;
            $display("FAIL trace_din_ready din_ready went high during traceback, expected 0");
        end
    endtask

    // Collects output bits. rmode 0: always ready, 1: 1,0,0 pattern, 2: random.
    task automatic recv_block(input int n, input int rmode, input bit junk);
        int   got = 0;
        int   cyc = 0;
        bit   done = 0;
        bit   have_hold = 0;
        logic hb, hl, r, e;
        while (!done && cyc < 400) begin
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            dout_ready = r;
            if (junk) begin
                din_valid = 1'b1;
                din_sel   = 8'($urandom_range(0, 255));
                din_last  = 1'b1;
            end
            if (have_hold) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_bit !== hb || dout_last !== hl) begin
                    failures++;
                    $display("FAIL stall_hold valid=%b bit=%b last=%b expected 1 %b %b",
                             dout_valid, dout_bit, dout_last, hb, hl);
                end
            end
            if (dout_valid === 1'b1) begin
                checks++;
                if (din_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL emit_din_ready din_ready=%b expected=0", din_ready);
                end
            end
            if (dout_valid === 1'b1 && r) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_bit index=%0d got=%b expected none", got, dout_bit);
                end else begin
                    e = exp_q.pop_front();
                    if (dout_bit !== e) begin
                        failures++;
                        $display("FAIL out_bit index=%0d got=%b expected=%b", got, dout_bit, e);
                    end
                end
                checks++;
                if (dout_last !== (got == n - 1)) begin
                    failures++;
                    $display("FAIL out_last index=%0d got=%b expected=%b", got, dout_last, (got == n - 1));
                end
                got++;
                if (dout_last === 1'b1 || got > n) done = 1;
                have_hold = 0;
            end else if (dout_valid === 1'b1) begin
                have_hold = 1;
                hb = dout_bit;
                hl = dout_last;
            end else begin
                have_hold = 0;
            end
            @(negedge clk);
            cyc++;
        end
        dout_ready = 1'b0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        checks++;
        if (got != n || exp_q.size() != 0) begin
            failures++;
            $display("FAIL out_count got=%0d left=%0d expected=%0d left=0", got, exp_q.size(), n);
        end
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            failures++;
            $display("FAIL back_to_fill valid=%b din_ready=%b expected 0 1", dout_valid, din_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (din_ready !== 1'b0 || dout_valid !== 1'b0 || dout_bit !== 1'b0 || dout_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b vld=%b bit=%b last=%b expected all 0",
                     din_ready, dout_valid, dout_bit, dout_last);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release din_ready=%b dout_valid=%b expected 1 0", din_ready, dout_valid);
        end
    endtask

    task automatic test_full_blocks();
        send_block(BL, 0, 3'd0, 1'b0, 1'b0); wait_trace(BL); recv_block(BL, 0, 1'b0);
        send_block(BL, 1, 3'd7, 1'b0, 1'b0); wait_trace(BL); recv_block(BL, 0, 1'b0);
        send_block(BL, 0, 3'd5, 1'b0, 1'b0); wait_trace(BL); recv_block(BL, 0, 1'b0);
    endtask

    task automatic test_short_block();
        send_block(5, 0, 3'd3, 1'b0, 1'b1); wait_trace(5); recv_block(5, 0, 1'b1);
        send_block(1, 0, 3'd1, 1'b0, 1'b0); wait_trace(1); recv_block(1, 0, 1'b0);
        send_block(BL, 2, 3'd6, 1'b1, 1'b0); wait_trace(BL); recv_block(BL, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        send_block(BL, 2, 3'd2, 1'b0, 1'b0); wait_trace(BL); recv_block(BL, 1, 1'b1);
        send_block(9, 2, 3'd4, 1'b0, 1'b0); wait_trace(9); recv_block(9, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) begin
            send_block(BL, 2, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
            wait_trace(BL);
            recv_block(BL, 2, 1'b1);
        end
    endtask

    task automatic test_reset_mid_trace();
        bit vld_seen = 0;
        bit rdy_bad = 0;
        send_block(BL, 1, 3'd7, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0) vld_seen = 1;
            if (din_ready !== 1'b1) rdy_bad = 1;
        end
        checks++;
        if (vld_seen) begin
            failures++;
            $display("FAIL abort_no_output dout_valid=1 seen after reset, expected 0");
        end
        checks++;
        if (rdy_bad) begin
            failures++;
            $display("FAIL abort_din_ready din_ready=0 seen after reset, expected 1");
        end
        send_block(BL, 0, 3'd0, 1'b0, 1'b0); wait_trace(BL); recv_block(BL, 0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_sel    = 8'h00;
        din_last   = 1'b0;
        end_state  = 3'd0;
        dout_ready = 1'b0;
        test_reset();
        test_full_blocks();
        test_short_block();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_trace();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
